basic_op_server: RTL and testbench



---
 rtl/basic_op_server.sv | 127 ++++++++++++
 tb/tb_basic_op_server.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/basic_op_server.sv
// Registered responder for G.729 L_mult / mult / L_mac / L_msu requests with ITU-T saturation.
// Define BASIC_OP_STICKY_OVF_EN to make the overflow flag sticky until reset or a clear request.
module basic_op_server (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] var1,
    input  logic [15:0] var2,
    input  logic [31:0] acc,
    output logic        done,
    output logic        busy,
    output logic [31:0] result,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    localparam logic [1:0] OP_L_MULT = 2'd0;
    localparam logic [1:0] OP_MULT   = 2'd1;
    localparam logic [1:0] OP_L_MSU  = 2'd3;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [15:0]        a_q, b_q;
    logic [31:0]        acc_q;
    logic signed [31:0] prod_q;

    logic signed [31:0] a_ext, b_ext, t;
    logic [31:0]        lm_res, res_nxt;
    logic               lm_sat, ovf_nxt;
    logic [32:0]        sum;

    assign a_ext = {{16{a_q[15]}}, a_q};
    assign b_ext = {{16{b_q[15]}}, b_q};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL:  state_nxt = ACC;
            ACC:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
        busy = (state != IDLE);
    end

    // Saturating arithmetic on the registered product.
    always_comb begin
        lm_sat  = (prod_q == 32'sh4000_0000);
        lm_res  = lm_sat ? 32'h7FFF_FFFF : {prod_q[30:0], 1'b0};
        t       = prod_q >>> 15;
        sum     = (op_q == OP_L_MSU) ? {acc_q[31], acc_q} - {lm_res[31], lm_res}
                                     : {acc_q[31], acc_q} + {lm_res[31], lm_res};
        res_nxt = lm_res;
        ovf_nxt = lm_sat;
        case (op_q)
            OP_L_MULT: ;
            OP_MULT: begin
                ovf_nxt = 1'b0;
                res_nxt = t;
                if (t > 32'sd32767) begin
                    res_nxt = 32'h0000_7FFF;
                    ovf_nxt = 1'b1;
                end else if (t < -32'sd32768) begin
                    res_nxt = 32'hFFFF_8000;
                    ovf_nxt = 1'b1;
                end
            end
            default: begin
                res_nxt = sum[31:0];
                if (sum[32] != sum[31]) begin
                    res_nxt = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    ovf_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    a_q   <= var1;
                    b_q   <= var2;
                    acc_q <= acc;
                end
                MUL: prod_q <= a_ext * b_ext;
                ACC: begin
                    result <= res_nxt;
`ifdef BASIC_OP_STICKY_OVF_EN
                    // An L_mult of 0 by 0 is the clear request for the sticky flag.
                    if (op_q == OP_L_MULT && a_q == 16'h0 && b_q == 16'h0)
                        overflow <= 1'b0;
                    else
                        overflow <= overflow | ovf_nxt;
`else
                    overflow <= ovf_nxt;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_op_server.sv
// Scoreboard bench for basic_op_server: reference model results queued at issue, compared on done.
module tb_basic_op_server;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op_i;
    logic [15:0] var1, var2;
    logic [31:0] acc_i;
    logic        done, busy, overflow;
    logic [31:0] result;

    typedef struct {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    logic sticky_m = 1'b0;

    basic_op_server dut (
        .clock(clock), .reset(reset), .start(start), .op(op_i),
        .var1(var1), .var2(var2), .acc(acc_i),
        .done(done), .busy(busy), .result(result), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [31:0] c, output logic [31:0] r, output logic v);
        longint p, lm, s;
        logic   lo;
        p = longint'($signed(a)) * longint'($signed(b));
        if (p == 64'sh4000_0000) begin lm = 64'sh7FFF_FFFF; lo = 1'b1; end
        else                     begin lm = p * 2;         lo = 1'b0; end
        v = lo;
        s = lm;
        case (o)
            2'd0: ;
            2'd1: begin
                s = p >>> 15;
                if (s > 32767)       begin s = 32767;  v = 1'b1; end
                else if (s < -32768) begin s = -32768; v = 1'b1; end
            end
            default: begin
                s = (o == 2'd2) ? longint'($signed(c)) + lm : longint'($signed(c)) - lm;
                if (s > 64'sh7FFF_FFFF)       begin s = 64'sh7FFF_FFFF; v = 1'b1; end
                else if (s < -64'sh8000_0000) begin s = -64'sh8000_0000; v = 1'b1; end
            end
        endcase
        r = s[31:0];
    endfunction

    // Monitor: every done pops one expectation.
    always @(negedge clock) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.r);
                check("overflow", {31'd0, overflow}, {31'd0, e.o});
            end
        end
    end

    task automatic push(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        exp_t e;
        model(o, a, b, c, e.r, e.o);
`ifdef BASIC_OP_STICKY_OVF_EN
        if (o == 2'd0 && a == 16'h0 && b == 16'h0) sticky_m = 1'b0;
        else                                      sticky_m = sticky_m | e.o;
        e.o = sticky_m;
`endif
        sb.push_back(e);
    endtask

    // Drive one request in an IDLE cycle, then scramble inputs to prove capture at start.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; op_i = o; var1 = a; var2 = b; acc_i = c;
        push(o, a, b, c);
        @(posedge clock);
        #1;
        start = 1'b0;
        op_i  = 2'($urandom);
        var1  = 16'($urandom);
        var2  = 16'($urandom);
        acc_i = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
        end while (!done && n < 8);
        check("latency", n, 3);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        issue(o, a, b, c);
        wait_done();
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op_i = '0; var1 = '0; var2 = '0; acc_i = '0;
        repeat (3) @(negedge clock);
        check("rst_result", result, 32'h0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        run_op(2'd0, 16'h4000, 16'h4000, 32'h0);
        run_op(2'd0, 16'h8000, 16'h8000, 32'h0);
        run_op(2'd1, 16'h8000, 16'h8000, 32'h0);
        run_op(2'd1, 16'hC000, 16'h4000, 32'h0);
        run_op(2'd1, 16'h7FFF, 16'h7FFF, 32'h0);
        run_op(2'd0, 16'h0000, 16'h0000, 32'h0);
        run_op(2'd2, 16'h0001, 16'h0100, 32'h7FFF_FFF0);
        run_op(2'd3, 16'h0001, 16'h0001, 32'h8000_0000);
        run_op(2'd2, 16'h8000, 16'h8000, 32'h0);
        run_op(2'd2, 16'h8000, 16'h7FFF, 32'h8000_0000);
        run_op(2'd3, 16'h1234, 16'hF00D, 32'h1234_5678);
        run_op(2'd0, 16'h0000, 16'h0000, 32'h0);

        // Start held during busy must be ignored; the next start after done is accepted.
        d0 = done_cnt;
        issue(2'd1, 16'h1000, 16'h2000, 32'h0);
        @(negedge clock);
        start = 1'b1; op_i = 2'd0; var1 = 16'h7FFF; var2 = 16'h0003; acc_i = 32'h5;
        @(negedge clock);
        @(negedge clock);
        check("busy_test_done", {31'd0, done}, 32'd1);
        start = 1'b0;
        run_op(2'd2, 16'h0003, 16'hFFFD, 32'h0000_0100);
        check("done_count", done_cnt - d0, 2);

        // Reset in the ACC cycle aborts without a done pulse.
        issue(2'd0, 16'h8000, 16'h8000, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        void'(sb.pop_back());
        sticky_m = 1'b0;
        @(negedge clock);
        check("abort_result", result, 32'h0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        run_op(2'd1, 16'h4000, 16'hC000, 32'h0);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] a, b;
            a = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
            b = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
            run_op(2'($urandom), a, b, (i % 3 == 0) ? 32'h7FFF_FF00 ^ {32{i[0]}} : $urandom);
        end

        repeat (4) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
